// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: load/store has priority over instruction fetch,
// except when fetch has been starved for STARVE_MAX cycles. Reads return data one cycle later.
module mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fe_req,
    input  logic [WIDTH-1:0] fe_addr,
    output logic             fe_gnt,
    output logic             fe_rvalid,
    output logic [WIDTH-1:0] fe_rdata,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [2:0]       ls_size,
    input  logic [WIDTH-1:0] ls_addr,
    input  logic [WIDTH-1:0] ls_wdata,
    output logic             ls_gnt,
    output logic             ls_rvalid,
    output logic [WIDTH-1:0] ls_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [2:0]       mem_size,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             fe_stall,
    output logic             ls_stall,
    output logic [1:0]       dbg_owner,
    output logic [2:0]       dbg_starve_cnt
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_FE   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    owner_t     owner, owner_next;
    logic [2:0] starve_cnt, starve_next;
    logic       fe_win;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner      <= OWN_NONE;
            starve_cnt <= 3'd0;
        end else begin
            owner      <= owner_next;
            starve_cnt <= starve_next;
        end
    end

    always_comb begin
        fe_win      = 1'b0;
        fe_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        owner_next  = OWN_NONE;
        starve_next = 3'd0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_size    = 3'd0;
        mem_addr    = '0;
        mem_wdata   = '0;

        // Fetch wins if it is alone, or once its starvation count reaches the limit.
        fe_win = fe_req && (!ls_req || starve_cnt >= STARVE_LIM);
        fe_gnt = reset_n && fe_win;
        ls_gnt = reset_n && ls_req && !fe_win;

        if (fe_gnt) begin
            owner_next = OWN_FE;
            mem_en     = 1'b1;
            mem_size   = 3'd2;
            mem_addr   = fe_addr;
        end else if (ls_gnt) begin
            owner_next = ls_we ? OWN_NONE : OWN_LS;
            mem_en     = 1'b1;
            mem_we     = ls_we;
            mem_size   = ls_size;
            mem_addr   = ls_addr;
            mem_wdata  = ls_wdata;
        end

        if (fe_req && !fe_gnt)
            starve_next = (starve_cnt >= STARVE_LIM) ? starve_cnt : starve_cnt + 3'd1;
    end

    // Reset masks the read-return path too, so an access in flight never reports valid.
    always_comb begin
        fe_rvalid      = reset_n && (owner == OWN_FE);
        ls_rvalid      = reset_n && (owner == OWN_LS);
        fe_rdata       = fe_rvalid ? mem_rdata : '0;
        ls_rdata       = ls_rvalid ? mem_rdata : '0;
        fe_stall       = reset_n && fe_req && !fe_gnt;
        ls_stall       = reset_n && ls_req && !ls_gnt;
        dbg_owner      = reset_n ? owner : 2'd0;
        dbg_starve_cnt = reset_n ? starve_cnt : 3'd0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter; two instances (STARVE_MAX 4 and 0)
// share stimulus and are compared with a per-cycle behavioural reference model.
module tb_mem_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         fe_req, ls_req, ls_we;
    logic [W-1:0] fe_addr, ls_addr, ls_wdata, mem_rdata;
    logic [2:0]   ls_size;

    logic         fe_gnt, fe_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, fe_stall, ls_stall;
    logic [W-1:0] fe_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [2:0]   mem_size, dbg_starve_cnt;
    logic [1:0]   dbg_owner;

    logic         fe_gnt1, fe_rvalid1, ls_gnt1, ls_rvalid1, mem_en1, mem_we1, fe_stall1, ls_stall1;
    logic [W-1:0] fe_rdata1, ls_rdata1, mem_addr1, mem_wdata1;
    logic [2:0]   mem_size1, dbg_starve_cnt1;
    logic [1:0]   dbg_owner1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state per instance: starvation count and who owns next cycle's read.
    int sm_val[2] = '{4, 0};
    int m_starve[2];
    int m_pend[2];   // 0 none, 1 fetch read pending, 2 load read pending

    logic obs_fe_gnt, obs_fe_gnt1, obs_mem_we, obs_fe_rvalid, obs_ls_rvalid;
    logic [2:0] obs_starve;

    mem_arbiter #(.WIDTH(W), .STARVE_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .fe_req(fe_req), .fe_addr(fe_addr), .fe_gnt(fe_gnt), .fe_rvalid(fe_rvalid), .fe_rdata(fe_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fe_stall(fe_stall), .ls_stall(ls_stall),
        .dbg_owner(dbg_owner), .dbg_starve_cnt(dbg_starve_cnt)
    );

    mem_arbiter #(.WIDTH(W), .STARVE_MAX(0)) dut_fixed (
        .clk(clk), .reset_n(reset_n),
        .fe_req(fe_req), .fe_addr(fe_addr), .fe_gnt(fe_gnt1), .fe_rvalid(fe_rvalid1), .fe_rdata(fe_rdata1),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt1), .ls_rvalid(ls_rvalid1), .ls_rdata(ls_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_size(mem_size1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata),
        .fe_stall(fe_stall1), .ls_stall(ls_stall1),
        .dbg_owner(dbg_owner1), .dbg_starve_cnt(dbg_starve_cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Who should win this cycle: 0 nobody, 1 fetch, 2 load/store.
    function automatic int model_grant(input int idx);
        if (!reset_n) return 0;
        if (fe_req && ls_req) return (m_starve[idx] >= sm_val[idx]) ? 1 : 2;
        if (fe_req) return 1;
        if (ls_req) return 2;
        return 0;
    endfunction

    task automatic step();
        int g0, g1;
        logic [W-1:0] e_addr, e_wdata;
        logic [2:0]   e_size;
        logic         e_frv, e_lrv;
        @(negedge clk);
        g0 = model_grant(0);
        g1 = model_grant(1);
        e_addr  = (g0 == 1) ? fe_addr : (g0 == 2) ? ls_addr : '0;
        e_wdata = (g0 == 2) ? ls_wdata : '0;
        e_size  = (g0 == 1) ? 3'd2 : (g0 == 2) ? ls_size : 3'd0;
        e_frv   = reset_n && m_pend[0] == 1;
        e_lrv   = reset_n && m_pend[0] == 2;

        check("fe_gnt", fe_gnt, g0 == 1);
        check("ls_gnt", ls_gnt, g0 == 2);
        check("mem_en", mem_en, g0 != 0);
        check("mem_we", mem_we, (g0 == 2) && ls_we);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("mem_size", mem_size, e_size);
        check("fe_stall", fe_stall, reset_n && fe_req && g0 != 1);
        check("ls_stall", ls_stall, reset_n && ls_req && g0 != 2);
        check("fe_rvalid", fe_rvalid, e_frv);
        check("ls_rvalid", ls_rvalid, e_lrv);
        check("fe_rdata", fe_rdata, e_frv ? mem_rdata : '0);
        check("ls_rdata", ls_rdata, e_lrv ? mem_rdata : '0);
        check("starve_cnt", dbg_starve_cnt, reset_n ? 3'(m_starve[0]) : 3'd0);

        check("fixed_fe_gnt", fe_gnt1, g1 == 1);
        check("fixed_ls_gnt", ls_gnt1, g1 == 2);
        check("fixed_fe_rvalid", fe_rvalid1, reset_n && m_pend[1] == 1);
        check("fixed_ls_rvalid", ls_rvalid1, reset_n && m_pend[1] == 2);

        obs_fe_gnt    = fe_gnt;
        obs_fe_gnt1   = fe_gnt1;
        obs_mem_we    = mem_we;
        obs_fe_rvalid = fe_rvalid;
        obs_ls_rvalid = ls_rvalid;
        obs_starve    = dbg_starve_cnt;

        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            int g;
            g = (i == 0) ? g0 : g1;
            if (!reset_n) begin
                m_starve[i] = 0;
                m_pend[i]   = 0;
            end else begin
                m_pend[i] = (g == 1) ? 1 : (g == 2 && !ls_we) ? 2 : 0;
                if (fe_req && g != 1)
                    m_starve[i] = (m_starve[i] + 1 > sm_val[i]) ? sm_val[i] : m_starve[i] + 1;
                else
                    m_starve[i] = 0;
            end
        end
        #1;
        mem_rdata = $urandom;
    endtask

    task automatic idle();
        fe_req = 1'b0;
        ls_req = 1'b0;
        ls_we  = 1'b0;
    endtask

    task automatic randomize_inputs();
        fe_req   = ($urandom_range(0, 3) != 0);
        ls_req   = ($urandom_range(0, 3) != 0);
        ls_we    = ($urandom_range(0, 2) == 0);
        ls_size  = 3'($urandom_range(0, 7));
        fe_addr  = $urandom;
        ls_addr  = $urandom;
        ls_wdata = $urandom;
        reset_n  = ($urandom_range(0, 60) != 0);
    endtask

    initial begin
        logic [5:0] fe_seq, fe_seq1;
        int pulses;
        m_starve = '{0, 0};
        m_pend   = '{0, 0};
        reset_n  = 1'b0;
        fe_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_size = 3'd1;
        fe_addr = 32'h100; ls_addr = 32'h200; ls_wdata = 32'h1234; mem_rdata = 32'hA5A5A5A5;
        step();
        step();

        // Single fetch, granted in the first cycle after reset release.
        reset_n = 1'b1;
        idle();
        fe_req = 1'b1; fe_addr = 32'h10;
        step();
        check("single_fetch_gnt", obs_fe_gnt, 1'b1);
        idle();
        step();
        check("single_fetch_rvalid", obs_fe_rvalid, 1'b1);

        // Conflict: load wins, fetch stalls.
        fe_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
        step();
        check("conflict_fe_gnt", obs_fe_gnt, 1'b0);
        idle();
        step();
        check("conflict_ls_rvalid", obs_ls_rvalid, 1'b1);
        check("conflict_fe_rvalid", obs_fe_rvalid, 1'b0);

        // Starvation: both held for six cycles.
        fe_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; fe_addr = 32'h80; ls_addr = 32'hC0;
        for (int c = 0; c < 6; c++) begin
            step();
            fe_seq[c]  = obs_fe_gnt;
            fe_seq1[c] = obs_fe_gnt1;
        end
        check("starve_seq", fe_seq, 6'b010000);
        check("fixed_prio_seq", fe_seq1, 6'b111111);
        idle();
        step();

        // Store.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h8; ls_wdata = 32'hDEADBEEF; ls_size = 3'd2;
        step();
        check("store_we", obs_mem_we, 1'b1);
        idle();
        step();
        check("store_no_rvalid", obs_ls_rvalid, 1'b0);

        // Pipelined fetch stream.
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            fe_req  = (c < 3);
            fe_addr = 32'(c * 4);
            step();
            if (c > 0 && obs_fe_rvalid) pulses++;
        end
        idle();
        step();
        if (obs_fe_rvalid) pulses++;
        check("stream_pulses", pulses, 3);

        // Reset asserted right after a load grant.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44; fe_req = 1'b1;
        step();
        reset_n = 1'b0;
        step();
        check("reset_ls_rvalid", obs_ls_rvalid, 1'b0);
        check("reset_starve", obs_starve, 3'd0);
        reset_n = 1'b1;
        idle();
        step();

        for (int c = 0; c < 600; c++) begin
            randomize_inputs();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
